// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
package uart_pkg;

    // Arbiter FSM: IDLE waits for a grant, WAIT_LOW waits for the
    // transmitter to take the byte (txrdy falling).
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    localparam int ACK_TIMEOUT_DEF = 7;
    localparam int MAX_BURST_DEF   = 16;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter handshake bundle for uart_tx_arb.
//
// Handshake: a requester raises req[i] with data[8i+7:8i] valid and holds both
// until it sees ack[i] for one cycle (the byte is consumed). The arbiter only
// pulses tx_load while txrdy=1, presenting tx_data in the same cycle; the
// transmitter then drops txrdy until its hold register is free again.
interface uart_tx_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   lock;
    logic [8*NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0]   ack;
    logic                 txrdy;
    logic [7:0]           tx_data;
    logic                 tx_load;

    // Environment side: requesters plus transmitter.
    modport master (
        output req, lock, data, txrdy,
        input  ack, tx_data, tx_load
    );

    // Arbiter side.
    modport slave (
        input  req, lock, data, txrdy,
        output ack, tx_data, tx_load
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin search: lowest requesting index at or after ptr, wrapping.
module uart_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    localparam logic [IW:0] NV = (IW + 1)'(N);

    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate req so bit 0 is ptr, take the first set bit, rotate the index back.
    always_comb begin
        shifted = {req, req} >> ptr;
        rot     = shifted[N-1:0];
        valid   = |req;
        off     = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = IW'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NV) begin
            sum = sum - NV;
        end
        idx = sum[IW-1:0];
    end
endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NUM_REQ byte requesters onto one UART transmit hold register,
// with round-robin fairness, bounded lock bursts and an ack-timeout flag.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MAX_BURST   = MAX_BURST_DEF,   // >= 2
    parameter  int ACK_TIMEOUT = ACK_TIMEOUT_DEF, // >= 2
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          err_clr,
    uart_tx_arb_if.slave  bus,
    output logic [IW-1:0] owner,
    output logic          busy,
    output logic          err,
    output state_t        state
);
    localparam int BW = $clog2(MAX_BURST);
    localparam int CW = $clog2(ACK_TIMEOUT);

    state_t               state_q, state_d;
    logic [IW-1:0]        rr_ptr;
    logic [BW-1:0]        burst_cnt;
    logic [CW-1:0]        wait_cnt;
    logic                 have_owner;  // owner holds a real grant, not the reset value
    logic                 tx_load_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [7:0]           tx_data_q;

    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic                 lock_hit;
    logic                 grant;
    logic                 timeout;
    logic [IW-1:0]        win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [7:0]           win_data;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Winner: the current owner keeps the link while it locks and has burst budget.
    always_comb begin
        lock_hit   = have_owner && bus.req[owner] && bus.lock[owner]
                     && (burst_cnt < BW'(MAX_BURST - 1));
        win_idx    = lock_hit ? owner : pick_idx;
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_onehot[i] = 1'b1;
                win_data      = bus.data[8*i +: 8];
            end
        end
    end

    // Next state; the txrdy sample in the tx_load cycle predates the load and is ignored.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && bus.txrdy && pick_valid) begin
                    grant   = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!tx_load_q && !bus.txrdy) begin
                    state_d = IDLE;
                end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant outputs, counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            wait_cnt   <= '0;
            have_owner <= 1'b0;
            owner      <= '0;
            tx_load_q  <= 1'b0;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            err        <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_load_q <= grant;
            ack_q     <= grant ? win_onehot : '0;
            if (grant) begin
                tx_data_q  <= win_data;
                owner      <= win_idx;
                have_owner <= 1'b1;
                rr_ptr     <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
                burst_cnt  <= lock_hit ? burst_cnt + BW'(1) : '0;
                wait_cnt   <= '0;
            end else if (state_q == WAIT_LOW) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (timeout) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.ack     = ack_q;
    assign bus.tx_load = tx_load_q;
    assign bus.tx_data = tx_data_q;
    assign busy        = (state_q != IDLE);
    assign state       = state_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NUM_REQ=4, MAX_BURST=4, ACK_TIMEOUT=7).
module tb_uart_tx_arb;
    import uart_pkg::*;

    typedef struct {
        logic       rst_before;
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] exp_ack;
        logic [1:0] exp_owner;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       err_clr;
    logic [1:0] owner;
    logic       busy;
    logic       err;
    state_t     state;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[19];

    uart_tx_arb_if #(.NUM_REQ(4)) bus ();

    uart_tx_arb #(.NUM_REQ(4), .MAX_BURST(4), .ACK_TIMEOUT(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .err_clr (err_clr),
        .bus     (bus),
        .owner   (owner),
        .busy    (busy),
        .err     (err),
        .state   (state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every tx_load must carry the next expected byte.
    always @(negedge clk) begin
        if (bus.tx_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load_unexpected: tx_data=%0h with no byte expected", bus.tx_data);
            end else begin
                check("load_data", bus.tx_data, exp_q.pop_front());
            end
        end
    end

    // One full grant + handshake from IDLE with txrdy=1.
    task automatic do_grant(input int n, input vec_t v);
        bus.req  = v.req;
        bus.lock = v.lock;
        exp_q.push_back(v.exp_data);
        step();
        check($sformatf("v%0d_ack", n), bus.ack, v.exp_ack);
        check($sformatf("v%0d_owner", n), owner, v.exp_owner);
        check($sformatf("v%0d_load", n), bus.tx_load, 1);
        check($sformatf("v%0d_busy", n), busy, 1);
        step();
        check($sformatf("v%0d_ack_pulse", n), bus.ack, 0);
        check($sformatf("v%0d_load_pulse", n), bus.tx_load, 0);
        bus.txrdy = 1'b0;
        step();
        check($sformatf("v%0d_idle", n), busy, 0);
        bus.txrdy = 1'b1;
    endtask

    initial begin
        // name: rst, req, lock, exp_ack, exp_owner, exp_data
        // Fairness from reset
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 8'hA5};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 8'h3C};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 8'h5A};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 8'hC3};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 8'hA5};
        // Burst limit with MAX_BURST=4: 0,0,0,0,1 repeating
        vecs[5]  = '{1'b1, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[6]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[7]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[8]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[9]  = '{1'b0, 4'b0011, 4'b0001, 4'b0010, 2'd1, 8'h3C};
        vecs[10] = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[11] = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[12] = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[13] = '{1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[14] = '{1'b0, 4'b0011, 4'b0001, 4'b0010, 2'd1, 8'h3C};
        // Lock on a non-owner is ignored; it counts once index 2 owns the link
        vecs[15] = '{1'b1, 4'b0111, 4'b0100, 4'b0001, 2'd0, 8'hA5};
        vecs[16] = '{1'b0, 4'b0111, 4'b0100, 4'b0010, 2'd1, 8'h3C};
        vecs[17] = '{1'b0, 4'b0111, 4'b0100, 4'b0100, 2'd2, 8'h5A};
        vecs[18] = '{1'b0, 4'b0111, 4'b0100, 4'b0100, 2'd2, 8'h5A};

        reset     = 1'b1;
        enable    = 1'b0;
        err_clr   = 1'b0;
        bus.req   = '0;
        bus.lock  = '0;
        bus.txrdy = 1'b1;
        bus.data  = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
        step();
        step();
        check("rst_load", bus.tx_load, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_data", bus.tx_data, 8'h00);
        check("rst_err", err, 0);
        check("rst_state", state, IDLE);
        reset  = 1'b0;
        enable = 1'b1;

        // Single request; txrdy low during the tx_load cycle must be ignored
        bus.req = 4'b0001;
        exp_q.push_back(8'hA5);
        step();
        check("single_load", bus.tx_load, 1);
        check("single_data", bus.tx_data, 8'hA5);
        check("single_ack", bus.ack, 4'b0001);
        check("single_owner", owner, 0);
        bus.req   = '0;
        bus.txrdy = 1'b0;
        step();
        check("single_first_ignored", busy, 1);
        check("single_load_pulse", bus.tx_load, 0);
        step();
        check("single_idle", busy, 0);
        bus.txrdy = 1'b1;

        // Table
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst_before) begin
                bus.req = '0;
                reset   = 1'b1;
                step();
                reset = 1'b0;
            end
            do_grant(i, vecs[i]);
        end
        bus.req  = '0;
        bus.lock = '0;

        // Enable gating; a WAIT_LOW in progress finishes with enable low
        enable  = 1'b0;
        bus.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("gate_no_ack", bus.ack, 0);
            check("gate_idle", busy, 0);
        end
        enable = 1'b1;
        exp_q.push_back(8'h5A);
        step();
        check("gate_ack", bus.ack, 4'b0100);
        check("gate_owner", owner, 2);
        bus.req = '0;
        enable  = 1'b0;
        step();
        bus.txrdy = 1'b0;
        step();
        check("gate_complete", busy, 0);
        enable    = 1'b1;
        bus.txrdy = 1'b1;

        // A request withdrawn before any grant edge is never granted
        enable  = 1'b0;
        bus.req = 4'b1000;
        step();
        bus.req = '0;
        enable  = 1'b1;
        step();
        check("drop_no_ack", bus.ack, 0);
        step();
        check("drop_idle", busy, 0);

        // Timeout: txrdy stuck high after a grant
        bus.req = 4'b0001;
        exp_q.push_back(8'hA5);
        step();
        check("to_load", bus.tx_load, 1);
        bus.req = '0;
        for (int i = 0; i < 6; i++) step();
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        step();
        check("to_err_set", err, 1);
        check("to_idle", state, IDLE);
        step();
        step();
        check("to_err_sticky", err, 1);
        check("to_no_regrant", bus.ack, 0);
        err_clr = 1'b1;
        step();
        check("to_err_clr", err, 0);
        err_clr = 1'b0;

        // Clear coinciding with a new timeout: set wins
        bus.req = 4'b0001;
        exp_q.push_back(8'hA5);
        step();
        bus.req = '0;
        for (int i = 0; i < 6; i++) step();
        check("tc_err_before", err, 0);
        err_clr = 1'b1;
        step();
        check("tc_set_wins", err, 1);
        err_clr = 1'b0;

        // Reset the cycle after a grant
        bus.req = 4'b0100;
        exp_q.push_back(8'h5A);
        step();
        check("rm_ack", bus.ack, 4'b0100);
        reset   = 1'b1;
        bus.req = 4'b1111;
        step();
        check("rm_load", bus.tx_load, 0);
        check("rm_ack_clr", bus.ack, 0);
        check("rm_busy", busy, 0);
        check("rm_owner", owner, 0);
        check("rm_data", bus.tx_data, 8'h00);
        check("rm_err", err, 0);
        reset = 1'b0;
        exp_q.push_back(8'hA5);
        step();
        check("rm_first_ack", bus.ack, 4'b0001);
        check("rm_first_owner", owner, 0);
        bus.req = '0;
        step();
        bus.txrdy = 1'b0;
        step();
        check("rm_idle", busy, 0);
        bus.txrdy = 1'b1;

        step();
        step();
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
